tcdm_lat_xbar: RTL and testbench

Single-channel, fully combinational-request TCDM crossbar connecting `NumMaster` initiators to `NumSlave` word-interleaved SRAM banks, with a parametrised bank read latency `MemLatency`. Per-bank round-robin arbitration and a per-bank response ID pipeline route `rdata_i` back to the granted master exactly `MemLatency` cycles after grant. It sits between the cluster cores/DMA ports and the TCDM bank array and is the next generation of the fixed-latency-1 TCDM crossbar wrapper.

---
 rtl/tcdm_lat_xbar_pkg.sv | 7 +
 rtl/tcdm_lat_xbar_rr_arb.sv | 35 +++
 rtl/tcdm_lat_xbar.sv | 115 +++++++++++
 tb/tb_tcdm_lat_xbar.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tcdm_lat_xbar_pkg.sv
// tcdm_xbar_pkg: shared helpers and constants for the latency-parametrised TCDM crossbar
package tcdm_xbar_pkg;
  localparam int unsigned RrPtrRst = 0;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tcdm_lat_xbar_rr_arb.sv
// tcdm_rr_arb: round-robin arbiter; search starts at the pointer, pointer moves past each winner
module tcdm_rr_arb
  import tcdm_xbar_pkg::*;
#(
  parameter int NumReq = 8,
  localparam int IdxW = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              vld_o
);
  logic [IdxW-1:0] ptr_q, ptr_d, cand;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand = '0;
    // descending scan so the candidate closest to the pointer is written last
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr_q) + i) % NumReq);
      if (req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
    gnt_o[idx_o] = vld_o;
    ptr_d = !vld_o ? ptr_q : (int'(idx_o) == NumReq - 1) ? '0 : idx_o + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    ptr_q <= rst_i ? IdxW'(RrPtrRst) : ptr_d;
  end
endmodule

// File: rtl/tcdm_lat_xbar.sv
// tcdm_lat_xbar: NumMaster x NumSlave TCDM crossbar with MemLatency-deep response routing.
// Optional TCDM_XBAR_RESP_REG_EN adds one response register stage (latency MemLatency+1).
module tcdm_lat_xbar
  import tcdm_xbar_pkg::*;
#(
  parameter int NumMaster    = 8,
  parameter int NumSlave     = 16,
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int AddrMemWidth = 12,
  parameter int MemLatency   = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumMaster-1:0]                    req_i,
  input  logic [NumMaster-1:0][AddrWidth-1:0]     add_i,
  input  logic [NumMaster-1:0]                    wen_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumMaster-1:0][BeWidth-1:0]       be_i,
  output logic [NumMaster-1:0]                    gnt_o,
  output logic [NumMaster-1:0]                    rvld_o,
  output logic [NumMaster-1:0][DataWidth-1:0]    rdata_o,
  output logic [NumSlave-1:0]                     cs_o,
  output logic [NumSlave-1:0][AddrMemWidth-1:0]   add_o,
  output logic [NumSlave-1:0]                     wen_o,
  output logic [NumSlave-1:0][DataWidth-1:0]      wdata_o,
  output logic [NumSlave-1:0][BeWidth-1:0]        be_o,
  input  logic [NumSlave-1:0][DataWidth-1:0]      rdata_i
);
  localparam int Off  = $clog2(BeWidth);
  localparam int Bw   = $clog2(NumSlave);
  localparam int IdxW = idx_width(NumMaster);
  logic [NumSlave-1:0][NumMaster-1:0]             bank_req, bank_gnt;
  logic [NumSlave-1:0][IdxW-1:0]                  bank_idx;
  logic [NumSlave-1:0]                            bank_vld;
  logic [NumSlave-1:0][MemLatency-1:0]            pv_q, pv_d;
  logic [NumSlave-1:0][MemLatency-1:0][IdxW-1:0]  pi_q, pi_d;
  logic [NumMaster-1:0]                           resp_vld_d;
  logic [NumMaster-1:0][DataWidth-1:0]            resp_data_d;
  logic                                           add_unused;
  // byte-offset and upper address bits are intentionally ignored
  assign add_unused = ^add_i;
  always_comb begin
    bank_req = '0;
    for (int s = 0; s < NumSlave; s++)
      for (int m = 0; m < NumMaster; m++)
        bank_req[s][m] = req_i[m] & ~rst_i & (add_i[m][Off +: Bw] == Bw'(s));
  end
  for (genvar b = 0; b < NumSlave; b++) begin : g_bank
    tcdm_rr_arb #(.NumReq(NumMaster)) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b]),
      .idx_o (bank_idx[b]),
      .vld_o (bank_vld[b])
    );
  end
  always_comb begin
    gnt_o   = '0;
    cs_o    = bank_vld;
    add_o   = '0;
    wen_o   = '0;
    wdata_o = '0;
    be_o    = '0;
    for (int s = 0; s < NumSlave; s++) begin
      gnt_o      = gnt_o | bank_gnt[s];
      add_o[s]   = bank_vld[s] ? add_i[bank_idx[s]][Off+Bw +: AddrMemWidth] : '0;
      wen_o[s]   = bank_vld[s] & wen_i[bank_idx[s]];
      wdata_o[s] = bank_vld[s] ? wdata_i[bank_idx[s]] : '0;
      be_o[s]    = bank_vld[s] ? be_i[bank_idx[s]] : '0;
    end
  end
  // per-bank shift line of {valid, winner} matching the bank read latency
  always_comb begin
    pv_d = pv_q;
    pi_d = pi_q;
    for (int s = 0; s < NumSlave; s++) begin
      pv_d[s][0] = bank_vld[s];
      pi_d[s][0] = bank_idx[s];
      for (int k = 1; k < MemLatency; k++) begin
        pv_d[s][k] = pv_q[s][k-1];
        pi_d[s][k] = pi_q[s][k-1];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    pv_q <= rst_i ? '0 : pv_d;
    pi_q <= rst_i ? '0 : pi_d;
  end
  always_comb begin
    resp_vld_d  = '0;
    resp_data_d = '0;
    for (int s = 0; s < NumSlave; s++) begin
      if (pv_q[s][MemLatency-1] && !rst_i) begin
        resp_vld_d[pi_q[s][MemLatency-1]]  = 1'b1;
        resp_data_d[pi_q[s][MemLatency-1]] = rdata_i[s];
      end
    end
  end
`ifdef TCDM_XBAR_RESP_REG_EN
  logic [NumMaster-1:0]                rvld_q;
  logic [NumMaster-1:0][DataWidth-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    rvld_q  <= rst_i ? '0 : resp_vld_d;
    rdata_q <= rst_i ? '0 : resp_data_d;
  end
  assign rvld_o  = rvld_q;
  assign rdata_o = rdata_q;
`else
  assign rvld_o  = resp_vld_d;
  assign rdata_o = resp_data_d;
`endif
endmodule

// File: tb/tb_tcdm_lat_xbar.sv
// tb_tcdm_lat_xbar: directed bench for tcdm_lat_xbar (default instance plus a MemLatency=3 instance)
module tb_tcdm_lat_xbar;
  localparam int NM = 8;
  localparam int NS = 16;
`ifdef TCDM_XBAR_RESP_REG_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif
  localparam int Lat  = 1 + Extra;
  localparam int Lat3 = 3 + Extra;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [NM-1:0]              req_i, wen_i;
  logic [NM-1:0][31:0]        add_i, wdata_i;
  logic [NM-1:0][3:0]         be_i;
  logic [NS-1:0][31:0]        rdata_i;
  logic [NM-1:0]              gnt, rvld, gnt3, rvld3;
  logic [NM-1:0][31:0]        rdata, rdata3;
  logic [NS-1:0]              cs, wen, cs3, wen3;
  logic [NS-1:0][11:0]        add, add3;
  logic [NS-1:0][31:0]        wdata, wdata3;
  logic [NS-1:0][3:0]         be, be3;
  int n_chk = 0;
  int n_fail = 0;
  bit [7:0] hist [8];
  always #5 clk_i = ~clk_i;
  tcdm_lat_xbar u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt), .rvld_o(rvld), .rdata_o(rdata),
    .cs_o(cs), .add_o(add), .wen_o(wen), .wdata_o(wdata), .be_o(be), .rdata_i(rdata_i)
  );
  tcdm_lat_xbar #(.MemLatency(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt3), .rvld_o(rvld3), .rdata_o(rdata3),
    .cs_o(cs3), .add_o(add3), .wen_o(wen3), .wdata_o(wdata3), .be_o(be3), .rdata_i(rdata_i)
  );
  function automatic logic [31:0] bdat(input int s);
    return 32'hDA7A_0000 | 32'(s);
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic clr();
    req_i = '0; wen_i = '0; add_i = '0; wdata_i = '0; be_i = '0;
  endtask
  task automatic put(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_i[m] = 1'b1; add_i[m] = a; wen_i[m] = w; wdata_i[m] = d; be_i[m] = 4'hF;
  endtask
  task automatic idle(input int n);
    clr();
    repeat (n) step();
  endtask
  initial begin
    for (int s = 0; s < NS; s++) rdata_i[s] = bdat(s);
    clr();
    step();
    step();
    // reset: request present but grant/chip-select forced low
    put(0, 32'h104, 1'b1, 32'h0);
    #1;
    chk("rst_gnt", 64'(gnt), 64'(8'h00));
    chk("rst_cs", 64'(cs), 64'(16'h0000));
    chk("rst_rvld", 64'(rvld), 64'(8'h00));
    chk("rst_rdata0", 64'(rdata[0]), 64'(32'h0));
    clr();
    rst_i = 1'b0;
    step();
    // single load, master 0 to bank 1 row 4
    put(0, 32'h104, 1'b1, 32'h1234_5678);
    #1;
    chk("s1_gnt", 64'(gnt), 64'(8'h01));
    chk("s1_cs", 64'(cs), 64'(16'h0002));
    chk("s1_add", 64'(add[1]), 64'(12'd4));
    chk("s1_wen", 64'(wen[1]), 64'(1'b1));
    chk("s1_wdata", 64'(wdata[1]), 64'(32'h1234_5678));
    chk("s1_be", 64'(be[1]), 64'(4'hF));
    chk("s1_idle_add", 64'(add[0]), 64'(12'd0));
    step();
    clr();
    repeat (Lat - 1) begin
      chk("s1_rvld_early", 64'(rvld), 64'(8'h00));
      step();
    end
    chk("s1_rvld", 64'(rvld), 64'(8'h01));
    chk("s1_rdata", 64'(rdata[0]), 64'(bdat(1)));
    chk("s1_rdata_idle", 64'(rdata[1]), 64'(32'h0));
    idle(6);
    // masters 0 and 3 fight over bank 5
    for (int i = 0; i < 4 + Lat; i++) begin
      clr();
      if (i < 4) begin
        put(0, 32'h14, 1'b1, 32'h0);
        put(3, 32'h14, 1'b1, 32'h0);
      end
      hist[i] = (i >= 4) ? 8'h00 : (i % 2 == 1) ? 8'h08 : 8'h01;
      #1;
      chk("rr_gnt", 64'(gnt), 64'(hist[i]));
      chk("rr_rvld", 64'(rvld), 64'((i >= Lat) ? hist[i-Lat] : 8'h00));
      if (i == Lat) chk("rr_rdata", 64'(rdata[0]), 64'(bdat(5)));
      step();
    end
    idle(6);
    // all masters to distinct banks, odd masters load, even masters store
    for (int m = 0; m < NM; m++) put(m, 32'(m * 4), m[0], 32'hA0 + 32'(m));
    #1;
    chk("all_gnt", 64'(gnt), 64'(8'hFF));
    chk("all_cs", 64'(cs), 64'(16'h00FF));
    chk("all_wen", 64'(wen), 64'(16'h00AA));
    chk("all_wdata5", 64'(wdata[5]), 64'(32'hA5));
    step();
    clr();
    repeat (Lat - 1) step();
    chk("all_rvld", 64'(rvld), 64'(8'hFF));
    chk("all_rdata6", 64'(rdata[6]), 64'(bdat(6)));
    chk("all_rdata3", 64'(rdata[3]), 64'(bdat(3)));
    idle(6);
    // reset while a response is in flight
    put(1, 32'h8, 1'b1, 32'h0);
    #1;
    chk("rm_gnt", 64'(gnt), 64'(8'h02));
    step();
    clr();
    rst_i = 1'b1;
    #1;
    chk("rm_rvld_in_rst", 64'(rvld), 64'(8'h00));
    step();
    rst_i = 1'b0;
    for (int k = 0; k < Lat + 1; k++) begin
      chk("rm_rvld_after", 64'(rvld), 64'(8'h00));
      step();
    end
    // bank 0 pointer was 1 before reset; reset must return priority to master 0
    put(0, 32'h0, 1'b1, 32'h0);
    put(1, 32'h40, 1'b1, 32'h0);
    #1;
    chk("rm_cf_gnt0", 64'(gnt), 64'(8'h01));
    chk("rm_cf_add0", 64'(add[0]), 64'(12'd0));
    step();
    chk("rm_cf_gnt1", 64'(gnt), 64'(8'h02));
    chk("rm_cf_add1", 64'(add[0]), 64'(12'd1));
    step();
    idle(6);
    // MemLatency=3: master 2 streams loads over banks 0..3
    for (int i = 0; i < 4 + Lat3; i++) begin
      int k;
      clr();
      if (i < 4) put(2, 32'(i * 4), 1'b1, 32'h0);
      k = i - Lat3;
      #1;
      chk("ml3_gnt", 64'(gnt3), 64'((i < 4) ? 8'h04 : 8'h00));
      chk("ml3_rvld", 64'(rvld3), 64'((k >= 0 && k < 4) ? 8'h04 : 8'h00));
      if (k >= 0 && k < 4) chk("ml3_rdata", 64'(rdata3[2]), 64'(bdat(k)));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
